// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared width, FSM state and operation encodings for multdiv_unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: start pulses, operands and result/strobe between execute stage and multdiv_unit.
// Latency: n/a (wires only).
// Backpressure: none; the pipeline stalls on this unit until data_resultRDY.
interface multdiv_if import multdiv_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/multdiv_addsub_w.sv
// addsub_w: WIDTH+1-bit adder/subtractor shared by the multiply accumulate and divide trial subtract.
// Latency: combinational.
// Backpressure: none.
module addsub_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);

  // Subtract when sub is set, otherwise add; result wraps modulo 2^(WIDTH+1).
  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: signed WIDTH-bit multicycle multiply (shift-add) / divide (restoring) on magnitudes.
// Latency: data_resultRDY strobes WIDTH+1 cycles after the start edge, independent of operands.
// Backpressure: none; a start in BUSY/DONE aborts and restarts, the caller stalls until the strobe.
module multdiv_unit import multdiv_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clock,
  input  logic       reset_n,
  multdiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  op_t              op;
  logic             neg;
  logic [WIDTH-1:0] dsor;    // multiplicand magnitude (MULT) or divisor magnitude (DIV)
  logic [WIDTH-1:0] hi;      // product high word / partial remainder
  logic [WIDTH-1:0] lo;      // multiplier shifting out, product low word / quotient shifting in
  logic [CW-1:0]    cnt;
  logic             start;
  logic             last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_a, add_b, add_y;
  logic             add_sub;
  logic [WIDTH-1:0] fin_res;
  logic             fin_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign last  = (cnt == CW'(WIDTH));
  assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign bus.data_resultRDY = (state == DONE);

  // Operand selection for the shared adder: accumulate for MULT, shifted trial subtract for DIV.
  always_comb begin
    add_sub = (op == OP_DIV);
    add_a   = {1'b0, hi};
    add_b   = lo[0] ? {1'b0, dsor} : '0;
    if (op == OP_DIV) begin
      add_a = {hi, lo[WIDTH-1]};
      add_b = {1'b0, dsor};
    end
  end

  addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  // Final sign fix-up and exception detection applied once all iterations are done.
  always_comb begin
    fin_res = '0;
    fin_exc = 1'b0;
    if (op == OP_MULT) begin
      fin_res = neg ? -lo : lo;
      fin_exc = (hi != '0) |
                (neg ? (lo[WIDTH-1] & (lo[WIDTH-2:0] != '0)) : lo[WIDTH-1]);
    end else if ((dsor == '0) || (!neg && lo[WIDTH-1])) begin
      fin_exc = 1'b1;
    end else begin
      fin_res = neg ? -lo : lo;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: a start pulse always (re)enters BUSY; BUSY leaves after the finalize edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (!start && last) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on start, iterate one bit per clock in BUSY, register result on the last edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op                 <= OP_MULT;
      neg                <= 1'b0;
      dsor               <= '0;
      hi                 <= '0;
      lo                 <= '0;
      cnt                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
    end else if (start) begin
      op   <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
      neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dsor <= bus.ctrl_MULT ? mag_a : mag_b;
      lo   <= bus.ctrl_MULT ? mag_b : mag_a;
      hi   <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      if (!last) begin
        cnt <= cnt + CW'(1);
        if (op == OP_MULT) begin
          hi <= add_y[WIDTH:1];
          lo <= {add_y[0], lo[WIDTH-1:1]};
        end else begin
          hi <= add_y[WIDTH] ? add_a[WIDTH-1:0] : add_y[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], ~add_y[WIDTH]};
        end
      end else begin
        bus.data_result    <= fin_res;
        bus.data_exception <= fin_exc;
      end
    end
  end

endmodule
